// File: rtl/instr_fetch.sv
// Instruction fetch front end: holds the fetch PC and issues in-order
// requests to instruction memory. Returned words are buffered with their PCs
// and handed to decode over a valid/ready handshake. Redirects flush the
// buffer, and words that were already requested on the wrong path are dropped
// when they come back.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        fetch_fault
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   // Architectural state
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] out_q, out_d;          // requests accepted, response not yet seen
   logic [CW-1:0] disc_q, disc_d;        // wrong-path responses still to drop
   logic          fault_q, fault_d;
   logic [PW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
   logic [PW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
   logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
   logic [31:0]   instr_q, instr_d;
   logic [31:0]   instr_pc_q, instr_pc_d;
   logic          instr_valid_q, instr_valid_d;

   // Storage arrays (data path only, no reset needed)
   logic [31:0] pcq_mem       [DEPTH];
   logic [31:0] fifo_data_mem [DEPTH];
   logic [31:0] fifo_pc_mem   [DEPTH];

   // Handshake qualifiers
   logic [CW:0]   credit_s;
   logic          req_valid_s, accept_s, pop_s, push_s;
   logic [CW-1:0] cnt_after_pop_s;
   logic [PW-1:0] rd_after_pop_s;

   // Request credit and the per-cycle push/pop/accept events
   always_comb begin
      credit_s        = {1'b0, out_q} + {1'b0, fifo_cnt_q};
      req_valid_s     = !rst && !fault_q && !redirect && (credit_s < DEPTH_C);
      accept_s        = req_valid_s && imem_req_ready;
      pop_s           = instr_valid_q && instr_ready;
      push_s          = imem_rsp_valid && (disc_q == CNT_ZERO) && !redirect;
      if (pop_s) begin
         cnt_after_pop_s = fifo_cnt_q - CNT_ONE;
         rd_after_pop_s  = fifo_rd_q + PTR_ONE;
      end else begin
         cnt_after_pop_s = fifo_cnt_q;
         rd_after_pop_s  = fifo_rd_q;
      end
   end

   // Next-state for PC, credit counters, pointers and the registered head
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      out_d         = out_q;
      disc_d        = disc_q;
      fault_d       = fault_q;
      pcq_wr_d      = pcq_wr_q;
      pcq_rd_d      = pcq_rd_q;
      fifo_wr_d     = fifo_wr_q;
      fifo_rd_d     = fifo_rd_q;
      fifo_cnt_d    = fifo_cnt_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = 1'b0;

      // Fetch PC: redirect target wins, otherwise advance on accept
      if (redirect) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
      end else if (accept_s) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
         fetch_pc_d = fetch_pc_q;
      end

      case ({accept_s, imem_rsp_valid})
         2'b10:   out_d = out_q + CNT_ONE;
         2'b01:   out_d = out_q - CNT_ONE;
         default: out_d = out_q;
      endcase

      if (accept_s) begin
         pcq_wr_d = pcq_wr_q + PTR_ONE;
      end else begin
         pcq_wr_d = pcq_wr_q;
      end
      if (imem_rsp_valid) begin
         pcq_rd_d = pcq_rd_q + PTR_ONE;
      end else begin
         pcq_rd_d = pcq_rd_q;
      end

      // Every word still in flight at a redirect is wrong-path; a response
      // landing in the redirect cycle itself is dropped immediately.
      if (redirect) begin
         disc_d = imem_rsp_valid ? (out_q - CNT_ONE) : out_q;
      end else if (imem_rsp_valid && (disc_q != CNT_ZERO)) begin
         disc_d = disc_q - CNT_ONE;
      end else begin
         disc_d = disc_q;
      end

      if (redirect && (redirect_pc[1:0] != 2'b00)) begin
         fault_d = 1'b1;
      end else begin
         fault_d = fault_q;
      end

      // FIFO bookkeeping and registered head
      if (redirect) begin
         fifo_wr_d     = '0;
         fifo_rd_d     = '0;
         fifo_cnt_d    = CNT_ZERO;
         instr_valid_d = 1'b0;
      end else begin
         fifo_wr_d  = push_s ? (fifo_wr_q + PTR_ONE) : fifo_wr_q;
         fifo_rd_d  = rd_after_pop_s;
         fifo_cnt_d = push_s ? (cnt_after_pop_s + CNT_ONE) : cnt_after_pop_s;
         if (cnt_after_pop_s != CNT_ZERO) begin
            instr_valid_d = 1'b1;
            instr_d       = fifo_data_mem[rd_after_pop_s];
            instr_pc_d    = fifo_pc_mem[rd_after_pop_s];
         end else if (push_s) begin
            // Word lands in an empty buffer: it becomes the new head
            instr_valid_d = 1'b1;
            instr_d       = imem_rsp_data;
            instr_pc_d    = pcq_mem[pcq_rd_q];
         end else begin
            instr_valid_d = 1'b0;
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         out_q         <= CNT_ZERO;
         disc_q        <= CNT_ZERO;
         fault_q       <= 1'b0;
         pcq_wr_q      <= '0;
         pcq_rd_q      <= '0;
         fifo_wr_q     <= '0;
         fifo_rd_q     <= '0;
         fifo_cnt_q    <= CNT_ZERO;
         instr_q       <= 32'h0000_0000;
         instr_pc_q    <= 32'h0000_0000;
         instr_valid_q <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         out_q         <= out_d;
         disc_q        <= disc_d;
         fault_q       <= fault_d;
         pcq_wr_q      <= pcq_wr_d;
         pcq_rd_q      <= pcq_rd_d;
         fifo_wr_q     <= fifo_wr_d;
         fifo_rd_q     <= fifo_rd_d;
         fifo_cnt_q    <= fifo_cnt_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   // Storage writes: in-flight PC queue on accept, buffer on a kept response
   always_ff @(posedge clk) begin
      if (accept_s) begin
         pcq_mem[pcq_wr_q] <= fetch_pc_q;
      end
      if (push_s) begin
         fifo_data_mem[fifo_wr_q] <= imem_rsp_data;
         fifo_pc_mem[fifo_wr_q]   <= pcq_mem[pcq_rd_q];
      end
   end

   assign imem_req_valid = req_valid_s;
   assign imem_addr      = fetch_pc_q;
   assign instruction    = instr_q;
   assign instr_pc       = instr_pc_q;
   assign instr_valid    = instr_valid_q;
   assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a latency-programmable in-order memory model, an
// expected-instruction queue filled by the directed tests, and a monitor that
// checks every word decode accepts against the queue.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] instruction;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        fetch_fault;

   int checks = 0;
   int errors = 0;

   // Memory model state
   int          cyc = 0;
   int          acc_count = 0;
   int          accept_limit = 0;
   int          mem_lat = 1;
   int          base = 0;
   logic [31:0] rsp_addr = 32'h0;
   logic [31:0] mq_addr [$];
   int          mq_due  [$];

   logic [63:0] exp_q [$];

   instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .redirect(redirect),
      .redirect_pc(redirect_pc), .instruction(instruction),
      .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push_exp(input logic [31:0] pc);
      exp_q.push_back({pc, mem_word(pc)});
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
   endtask

   // Reset, program memory latency / accept budget / decode ready, then release
   task automatic start_test(input int lat, input int n_acc, input logic rdy);
      rst = 1'b1;
      redirect = 1'b0;
      mem_lat = lat;
      accept_limit = acc_count + n_acc;
      base = acc_count;
      instr_ready = rdy;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Memory: responds in order mem_lat cycles after each accepted request
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      imem_req_ready = 1'b0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            rsp_addr       = mq_addr.pop_front();
            void'(mq_due.pop_front());
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(rsp_addr);
         end else begin
            imem_rsp_valid = 1'b0;
         end
         imem_req_ready = (acc_count < accept_limit) ? 1'b1 : 1'b0;
         @(negedge clk);
         if (rst) begin
            mq_addr.delete();
            mq_due.delete();
         end else if (imem_req_valid && imem_req_ready) begin
            mq_addr.push_back(imem_addr);
            mq_due.push_back(cyc + mem_lat);
            acc_count++;
         end
      end
   end

   // Monitor: every word accepted by decode must match the queue head
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (!rst && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scoreboard unexpected: got pc %h expected none", instr_pc);
            end else begin
               e = exp_q.pop_front();
               chk("scoreboard pc", instr_pc, e[63:32]);
               chk("scoreboard instr", instruction, e[31:0]);
            end
         end
      end
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      redirect = 1'b0;
      redirect_pc = 32'h0;
      instr_ready = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      chk("reset req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("reset addr", imem_addr, 32'h0);
      chk("reset instr_valid", {31'd0, instr_valid}, 32'd0);
      chk("reset instruction", instruction, 32'h0);
      chk("reset instr_pc", instr_pc, 32'h0);
      chk("reset fault", {31'd0, fetch_fault}, 32'd0);

      // 1: in-order fetch, first word two cycles after first accept
      start_test(1, 4, 1'b1);
      push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
      @(negedge clk);
      chk("t1 first req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("t1 first addr", imem_addr, 32'h0);
      tick(); @(negedge clk);
      chk("t1 second addr", imem_addr, 32'h4);
      chk("t1 no early valid", {31'd0, instr_valid}, 32'd0);
      tick(); @(negedge clk);
      chk("t1 first valid", {31'd0, instr_valid}, 32'd1);
      chk("t1 first pc", instr_pc, 32'h0);
      wait_drain(40);

      // 2: decode stalled, credit limits accepts to DEPTH
      start_test(1, 3, 1'b0);
      repeat (10) tick();
      chk("t2 accepts while stalled", 32'(acc_count - base), 32'd2);
      @(negedge clk);
      chk("t2 hold valid", {31'd0, instr_valid}, 32'd1);
      chk("t2 hold pc", instr_pc, 32'h0);
      push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
      tick();
      instr_ready = 1'b1;
      wait_drain(40);

      // 3: redirect with two requests in flight
      start_test(3, 6, 1'b1);
      push_exp(32'h0); push_exp(32'h4); push_exp(32'h100); push_exp(32'h104);
      for (int i = 0; i < 30 && (acc_count - base) < 4; i++) tick();
      chk("t3 reached two in flight", 32'(acc_count - base), 32'd4);
      redirect = 1'b1;
      redirect_pc = 32'h100;
      @(negedge clk);
      chk("t3 req blocked by redirect", {31'd0, imem_req_valid}, 32'd0);
      tick();
      redirect = 1'b0;
      wait_drain(60);

      // 4: redirect in the same cycle as the response for 0x4
      start_test(1, 4, 1'b1);
      push_exp(32'h0); push_exp(32'h40); push_exp(32'h44);
      for (int i = 0; i < 20 && !(imem_rsp_valid && rsp_addr == 32'h4); i++) tick();
      chk("t4 rsp 0x4 seen", rsp_addr, 32'h4);
      redirect = 1'b1;
      redirect_pc = 32'h40;
      tick();
      redirect = 1'b0;
      wait_drain(40);

      // 5: misaligned redirect sets the sticky fault and blocks fetch
      start_test(1, 2, 1'b1);
      push_exp(32'h0); push_exp(32'h4);
      tick(); tick(); tick();
      redirect = 1'b1;
      redirect_pc = 32'h102;
      tick();
      redirect = 1'b0;
      @(negedge clk);
      chk("t5 fault set", {31'd0, fetch_fault}, 32'd1);
      for (int i = 0; i < 20; i++) begin
         tick();
         @(negedge clk);
         chk("t5 no req while faulted", {31'd0, imem_req_valid}, 32'd0);
      end
      wait_drain(5);
      start_test(1, 1, 1'b1);
      push_exp(32'h0);
      @(negedge clk);
      chk("t5 fault cleared", {31'd0, fetch_fault}, 32'd0);
      chk("t5 restart req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("t5 restart addr", imem_addr, 32'h0);
      wait_drain(20);

      // 6: reset with the buffer full and memory not ready
      start_test(1, 2, 1'b0);
      repeat (6) tick();
      @(negedge clk);
      chk("t6 full valid", {31'd0, instr_valid}, 32'd1);
      chk("t6 addr before rst", imem_addr, 32'h8);
      tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk("t6 instr_valid after rst", {31'd0, instr_valid}, 32'd0);
      chk("t6 addr after rst", imem_addr, 32'h0);
      chk("t6 req_valid after rst", {31'd0, imem_req_valid}, 32'd0);
      chk("t6 instr_pc after rst", instr_pc, 32'h0);

      chk("final queue empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
